// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD arithmetic front-end and datapath:
// op encodings, controller FSM states and the request priority encoder.
package bcd_ctrl_pkg;

  localparam int unsigned NUM_CH = 4;

  localparam logic [1:0] OP_ADD1 = 2'd0;
  localparam logic [1:0] OP_ADD2 = 2'd1;
  localparam logic [1:0] OP_MUL2 = 2'd2;
  localparam logic [1:0] OP_MUL3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    LOCKED = 2'd3
  } state_e;

  // Lowest set index wins.
  function automatic logic [1:0] prio_enc(input logic [NUM_CH-1:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/trigger_holdoff.sv
// One trigger channel: 2-flop synchroniser, rising-edge detect and a
// hold-off counter that masks further edges for HOLDOFF_CYCLES cycles.
module trigger_holdoff #(
  parameter int unsigned HOLDOFF_CYCLES = 2048,
  parameter int unsigned CNT_W          = 12
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  output logic accept_o
);

  logic             meta_q, sync_q, sync_qq;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= trig_i;
      sync_q  <= meta_q;
      sync_qq <= sync_q;
      cnt_q   <= cnt_d;
    end
  end

  assign accept_o = sync_q & ~sync_qq & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (accept_o)          cnt_d = CNT_W'(HOLDOFF_CYCLES);
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

endmodule

// File: rtl/bcd_op_scheduler.sv
// Front-end controller for the BCD datapath: debounced trigger events are
// queued per channel and issued one at a time over valid/ready + done.
module bcd_op_scheduler
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 2048,
  parameter int unsigned CNT_W          = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] Trigger,
  input  logic              OpReady,
  input  logic              OpDone,
  input  logic              Overflow,
  output logic              OpValid,
  output logic [1:0]        OpCode,
  output logic              Busy,
  output logic              Locked,
  output logic [NUM_CH-1:0] Pending,
  output logic              Drop
);

  if (HOLDOFF_CYCLES >= 2**CNT_W) begin : g_cnt_w_check
    $error("CNT_W too narrow for HOLDOFF_CYCLES");
  end

  logic [NUM_CH-1:0] accept;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trigger_holdoff #(
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
      .CNT_W         (CNT_W)
    ) u_holdoff (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .trig_i  (Trigger[i]),
      .accept_o(accept[i])
    );
  end

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d, clr, keep, set;
  logic [1:0]        opc_q, opc_d;
  logic              drop_q, drop_d;
  logic              locked_w;

  assign locked_w = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    clr     = '0;
    OpValid = 1'b0;
    case (state_q)
      IDLE: if (|pend_q) begin
        state_d = ISSUE;
        opc_d   = prio_enc(pend_q);
        clr     = NUM_CH'(1) << prio_enc(pend_q);
      end
      ISSUE: begin
        OpValid = 1'b1;
        if (OpReady) state_d = OpDone ? IDLE : WAIT;
      end
      WAIT:    if (OpDone) state_d = IDLE;
      default: state_d = LOCKED;
    endcase
    if (Overflow) state_d = LOCKED;

    // A bit being issued this cycle may be re-set by a fresh edge.
    keep   = pend_q & ~clr;
    set    = accept & ~keep;
    drop_d = |(accept & (keep | {NUM_CH{locked_w | Overflow}}));
    pend_d = (locked_w || Overflow) ? '0 : (keep | set);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      opc_q   <= OP_ADD1;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      opc_q   <= opc_d;
      drop_q  <= drop_d;
    end
  end

  assign OpCode  = opc_q;
  assign Busy    = (state_q == ISSUE) || (state_q == WAIT);
  assign Locked  = locked_w;
  assign Pending = pend_q;
  assign Drop    = drop_q;

endmodule
